// File: rtl/aes_round_sched.sv
// rtl/aes_round_sched.sv - iterative AES round sequencer (optional abort: AES_ROUND_SCHED_ABORT_EN)
module aes_round_sched #(
    parameter int NR        = 10,
    parameter int ROUND_LAT = 5,
    parameter int FINAL_LAT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic [127:0] dp_state,
    output logic [127:0] dp_key,
    input  logic [127:0] dp_round_out,
    input  logic [127:0] dp_final_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block
`ifdef AES_ROUND_SCHED_ABORT_EN
    ,
    input  logic         abort
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    localparam logic [3:0] NR_C   = 4'(NR);
    localparam logic [3:0] LAST_C = 4'(NR - 1);
    localparam logic [3:0] RL_C   = 4'(ROUND_LAT);
    localparam logic [3:0] FL_C   = 4'(FINAL_LAT);

    state_t       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] ob_q, ob_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   round_q, round_d;

    // Next-state logic: the state register and key index stay frozen while the
    // datapath pipeline fills, and the result is captured once cnt saturates.
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        ob_d    = ob_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    st_d    = in_block ^ rk_data;
                    round_d = 4'd1;
                    cnt_d   = 4'd0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (cnt_q != RL_C) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    st_d  = dp_round_out;
                    cnt_d = 4'd0;
                    if (round_q == LAST_C) begin
                        round_d = NR_C;
                        state_d = S_FINAL;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end
            S_FINAL: begin
                if (cnt_q != FL_C) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    ob_d    = dp_final_out;
                    cnt_d   = 4'd0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    round_d = 4'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef AES_ROUND_SCHED_ABORT_EN
        // Abort discards the block in flight but leaves the last ciphertext intact.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            st_d    = st_q;
            ob_d    = ob_q;
            cnt_d   = 4'd0;
            round_d = 4'd0;
        end
`endif
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            st_q    <= '0;
            ob_q    <= '0;
            cnt_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            ob_q    <= ob_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
        end
    end

    // Key index: 0 for the whitening key, round number while iterating, NR for the final round.
    always_comb begin
        rk_idx = 4'd0;
        case (state_q)
            S_ROUND:          rk_idx = round_q;
            S_FINAL, S_DONE:  rk_idx = NR_C;
            default:          rk_idx = 4'd0;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign dp_state  = st_q;
    assign dp_key    = rk_data;
    assign out_block = ob_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// tb/tb_aes_round_sched.sv - scoreboard bench for aes_round_sched with stub datapaths
module tb_aes_round_sched;

    localparam int NR  = 10;
    localparam int RL  = 5;
    localparam int FL  = 3;
    localparam int LAT = (NR - 1) * (RL + 1) + FL + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic [127:0] dp_state;
    logic [127:0] dp_key;
    logic [127:0] dp_round_out;
    logic [127:0] dp_final_out;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         abort;

    logic [127:0] keys [16];
    logic [127:0] rp [RL];
    logic [127:0] fp [FL];

    typedef struct {
        logic [127:0] data;
        int           acc;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pushes = 0;
    int last_acc = -1;
    bit b2b = 1'b0;
    logic         pv = 1'b0;
    logic [127:0] pb = '0;

    aes_round_sched #(.NR(NR), .ROUND_LAT(RL), .FINAL_LAT(FL)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_block(in_block),
        .rk_idx(rk_idx),
        .rk_data(rk_data),
        .dp_state(dp_state),
        .dp_key(dp_key),
        .dp_round_out(dp_round_out),
        .dp_final_out(dp_final_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_block(out_block)
`ifdef AES_ROUND_SCHED_ABORT_EN
        ,
        .abort(abort)
`endif
    );

    always #5 clk = ~clk;

    assign rk_data      = keys[rk_idx];
    assign dp_round_out = rp[RL-1];
    assign dp_final_out = fp[FL-1];

    // Stub datapaths: round = (state+1)^key after RL cycles, final = ~state^key after FL cycles.
    always @(posedge clk) begin
        rp[0] <= (dp_state + 128'd1) ^ dp_key;
        for (int i = 1; i < RL; i++) rp[i] <= rp[i-1];
        fp[0] <= ~dp_state ^ dp_key;
        for (int i = 1; i < FL; i++) fp[i] <= fp[i-1];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ keys[0];
        for (int r = 1; r < NR; r++) s = (s + 128'd1) ^ keys[r];
        return ~s ^ keys[NR];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stimulus side of the scoreboard: every accepted block pushes its expected ciphertext.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready && !abort) begin
            q.push_back('{data: model(in_block), acc: cyc + 1});
            pushes <= pushes + 1;
            if (b2b && last_acc >= 0) chk("b2b_spacing", 128'(cyc + 1 - last_acc), 128'(60));
            last_acc <= cyc + 1;
        end else if (!b2b) begin
            last_acc <= -1;
        end
    end

    // Monitor: checks timing, key index and data against the scoreboard head.
    always @(negedge clk) begin
        int d;
        int e;
        if (rst_n && !abort) begin
            if (q.size() > 0 && cyc >= q[0].acc) begin
                d = cyc - q[0].acc;
                e = (d < (NR - 1) * (RL + 1)) ? (d / (RL + 1) + 1) : NR;
                chk("rk_idx", 128'(rk_idx), 128'(e));
                chk("out_valid_timing", 128'(out_valid), 128'(d >= LAT));
                chk("in_ready_busy", 128'(in_ready), 128'(0));
                if (out_valid && out_ready) begin
                    chk("out_block", out_block, q[0].data);
                    void'(q.pop_front());
                end
            end else begin
                chk("idle_out_valid", 128'(out_valid), 128'(0));
                chk("idle_in_ready", 128'(in_ready), 128'(1));
            end
            if (out_valid && pv) chk("out_block_stable", out_block, pb);
        end
        pv <= out_valid;
        pb <= out_block;
    end

    task automatic reset_state_check();
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_block", out_block, 128'(0));
        chk("rst_rk_idx", 128'(rk_idx), 128'(0));
        chk("rst_dp_state", dp_state, 128'(0));
    endtask

    task automatic accept(input logic [127:0] pt);
        int n;
        n = pushes;
        in_block = pt;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && pushes == n; i++) begin
            @(posedge clk);
            #1;
        end
        chk("accept_timeout", 128'(pushes - n), 128'(1));
        in_valid = 1'b0;
        in_block = rnd128();
    endtask

    task automatic wait_idle(input int bound, input bit rnd_ready);
        for (int i = 0; i < bound && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
        chk("idle_timeout", 128'(q.size()), 128'(0));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_block  = '0;
        out_ready = 1'b1;
        abort     = 1'b0;
        for (int i = 0; i < 16; i++) keys[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_state_check();

        // Zero keys: result must be ~(pt + NR - 1).
        for (int k = 0; k < 2; k++) begin
            logic [127:0] pt;
            pt = (k == 0) ? 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA : rnd128();
            chk("zero_key_model", model(pt), ~(pt + 128'd9));
            accept(pt);
            wait_idle(300, 1'b0);
        end

        // Random keys and random output backpressure.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i <= NR; i++) keys[i] = rnd128();
            accept(rnd128());
            wait_idle(600, 1'b1);
        end

        // Back-to-back with in_valid held high.
        b2b = 1'b1;
        p0 = pushes;
        in_valid = 1'b1;
        for (int i = 0; i < 190; i++) begin
            in_block = rnd128();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("b2b_count", 128'(pushes - p0), 128'(4));
        wait_idle(300, 1'b0);
        b2b = 1'b0;

        // Backpressure: hold out_ready low for 20 cycles after out_valid.
        out_ready = 1'b0;
        accept(rnd128());
        for (int i = 0; i < 200 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_valid_seen", 128'(out_valid), 128'(1));
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_after", 128'(in_ready), 128'(1));
        wait_idle(100, 1'b0);

        // Reset in the middle of round 4, then a fresh block.
        accept(rnd128());
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_state_check();
        keys[3] = rnd128();
        accept(rnd128());
        wait_idle(300, 1'b0);

`ifdef AES_ROUND_SCHED_ABORT_EN
        // Abort during FINAL: no output, then the next block completes.
        accept(rnd128());
        repeat (55) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_in_ready", 128'(in_ready), 128'(1));
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        repeat (70) begin
            @(posedge clk);
            #1;
        end
        accept(rnd128());
        wait_idle(300, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_sched.md
# aes_round_sched

Iterative AES encryption controller that sequences one shared full-round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey; 5-cycle latency) and one final-round datapath (no MixColumns; 3-cycle latency). It accepts one 128-bit block per transaction and performs the initial AddRoundKey itself. It then feeds the state back through the round datapath NR-1 times and once through the final-round datapath, and returns the ciphertext on a valid/ready output port. It also drives the round-key index to an external key-schedule store.

## Interface
- `NR`, default 10: number of AES rounds (10/12/14); legal range 2..15.
- `ROUND_LAT`, default 5: full-round datapath latency in cycles, input to registered output.
- `FINAL_LAT`, default 3: final-round datapath latency in cycles.
- `clk` in 1: clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: plaintext block offered.
- `in_ready` out 1: controller idle, block can be accepted.
- `in_block` in 128: plaintext.
- `rk_idx` out 4: round-key index requested.
- `rk_data` in 128: round key for `rk_idx`, combinational from the key store, same cycle.
- `dp_state` out 128: state fed to both datapaths; equals the internal state register.
- `dp_key` out 128: key fed to both datapaths; equals `rk_data`.
- `dp_round_out` in 128: full-round datapath result.
- `dp_final_out` in 128: final-round datapath result.
- `out_valid` out 1: ciphertext valid.
- `out_ready` in 1: consumer accepts ciphertext.
- `out_block` out 128: ciphertext, registered.
- `abort` in 1: present only with `AES_ROUND_SCHED_ABORT_EN`.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE.
  - IDLE: `in_ready`=1, `rk_idx`=0. On `in_valid`&&`in_ready`:
    - `st_reg <= in_block ^ rk_data`
    - `round <= 1`, `cnt <= 0`
    - go to ROUND.
  - ROUND: `rk_idx`=`round`. Each edge with `cnt`!=`ROUND_LAT`: `cnt++`. At the edge with `cnt`==`ROUND_LAT`:
    - `st_reg <= dp_round_out`, `cnt <= 0`
    - if `round`==`NR-1`: `round <= NR`, go to FINAL
    - else `round++`.
  - FINAL: `rk_idx`=`NR`. Each edge with `cnt`!=`FINAL_LAT`: `cnt++`. At the edge with `cnt`==`FINAL_LAT`: `out_block <= dp_final_out`, go to DONE.
  - DONE: `out_valid`=1, `rk_idx`=`NR`. On `out_valid`&&`out_ready`: go to IDLE, `round <= 0`.
- `st_reg` and `rk_idx` are stable for the whole wait of each round. The datapath pipeline is therefore fully overwritten before capture, and no datapath flush or reset is required.
- `in_ready` is high only in IDLE. There is no overlap between blocks, and `in_ready` is low in the DONE cycle that sees the output handshake.
- `out_block` holds its value from the FINAL capture until overwritten by the next block's capture. It does not change while `out_valid`=1.
- `cnt` is 4 bits and saturates at its compare value. `round` is 4 bits and never wraps past `NR`.
- Reset (`rst_n`=0 at an edge, any state, mid-round included):
  - FSM to IDLE.
  - `st_reg`, `out_block`, `cnt`, `round` all 0.
  - `out_valid`=0, `in_ready`=1 from the following cycle.

## Timing
- Accept at edge E0. Round r (r = 1..NR-1) captures at edge E0 + r·(`ROUND_LAT`+1).
- FINAL is entered at the last round capture. The final capture falls `FINAL_LAT`+1 edges after FINAL entry.
- Total latency from accept edge to `out_valid` rising is (NR−1)(`ROUND_LAT`+1) + `FINAL_LAT` + 1. With defaults this is 9·6 + 4 = 58 cycles.
- Minimum block period is 60 cycles: 58, plus 1 DONE cycle with immediate `out_ready`, plus 1 IDLE accept.
- `in_valid` asserted during busy states is ignored (no accept). `in_block` need not be held after the accept edge.
- If `out_ready` is held low, DONE persists indefinitely. `out_valid` remains 1 and `in_ready` remains 0.
- Outputs after reset: `in_ready`=1, `out_valid`=0, `out_block`=0, `rk_idx`=0, `dp_state`=0.

## Configuration
- `AES_ROUND_SCHED_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort`=1 at an edge in ROUND, FINAL or DONE goes to IDLE, clears `cnt` and `round`, drops `out_valid`, and discards the block. `out_block` keeps its previous value.
  - `abort` in IDLE is ignored.
  - Simultaneous `abort` and output handshake in DONE behaves identically, going to IDLE.
  - `abort` has priority below `rst_n`.
- Not defined: no `abort` port; a block runs to completion once accepted.

## Test plan
- FIPS-197 App. B, through real datapaths and a key-schedule model:
  - Plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: `out_block`=3925841d02dc09fbdc118597196a0b32, `out_valid` rising exactly 58 cycles after the accept edge.
- Behavioural stub datapaths (round: state+1 after 5 cycles; final: state^FF..FF after 3 cycles) with all-zero keys:
  - Required: `rk_idx` sequence 0, 1×6 cycles, …, 9×6 cycles, 10.
  - Required: `out_block`=~(in_block+9).
- Back-to-back: `in_valid` held high with `out_ready`=1.
  - Required: accepts exactly 60 cycles apart; `in_valid` ignored while busy.
- Backpressure: `out_ready`=0 for 20 cycles after `out_valid`.
  - Required: `out_valid` and `out_block` stable; `in_ready`=0 throughout; IDLE one cycle after `out_ready` rises.
- Reset mid-round 4:
  - `rst_n`=0 for 1 cycle. Required: all outputs at reset values next cycle.
  - A new block then yields the correct result with no stale datapath contents.
- With `AES_ROUND_SCHED_ABORT_EN`:
  - `abort` in FINAL: required `out_valid` never asserts, `in_ready`=1 next cycle.
  - The following block completes correctly.
